// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin drain of two virtual-channel FIFOs into two destination FIFOs.
// Optional macro STRICT_PRIORITY_EN replaces the weighted arbitration with absolute VC0 priority.
module vc_wrr_scheduler #(
   parameter int BW      = 6,
   parameter int WEIGHT0 = 3,
   parameter int WEIGHT1 = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          vc0_empty,
   input  logic          vc1_empty,
   input  logic [BW-1:0] vc0_data,
   input  logic [BW-1:0] vc1_data,
   input  logic          d0_pause,
   input  logic          d1_pause,
   output logic          vc0_rd,
   output logic          vc1_rd,
   output logic          d0_wr,
   output logic          d1_wr,
   output logic [BW-1:0] d_data,
   output logic [1:0]    grant,
   output logic          misroute_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT0 = 2'b01,
      GRANT1 = 2'b10
   } state_t;

   state_t        r_state;
   logic          r_valid;
   logic          r_src;
   logic          r_d0_wr;
   logic          r_d1_wr;
   logic [BW-1:0] r_d_data;
   logic          r_misroute;

   logic          w_can_pop;
   logic [BW-1:0] w_word;
   logic          w_bad_class;

   // Both pauses gate the pop because the destination is only known once data returns.
   assign w_can_pop = enable & ~d0_pause & ~d1_pause;
   assign vc0_rd    = (r_state == GRANT0) & w_can_pop & ~vc0_empty;
`ifdef STRICT_PRIORITY_EN
   assign vc1_rd    = (r_state == GRANT1) & w_can_pop & ~vc1_empty & vc0_empty;
`else
   assign vc1_rd    = (r_state == GRANT1) & w_can_pop & ~vc1_empty;
`endif

`ifdef STRICT_PRIORITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (!vc0_empty)      r_state <= GRANT0;
               else if (!vc1_empty) r_state <= GRANT1;
            end
            GRANT0: begin
               if (vc0_empty) r_state <= vc1_empty ? IDLE : GRANT1;
            end
            GRANT1: begin
               if (!vc0_empty)     r_state <= GRANT0;
               else if (vc1_empty) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
`else
   // A weight of 0 behaves as 1, so the last grant index saturates at 0.
   localparam logic [3:0] LP_LAST0 = (WEIGHT0 < 2) ? 4'd0 : 4'(WEIGHT0 - 1);
   localparam logic [3:0] LP_LAST1 = (WEIGHT1 < 2) ? 4'd0 : 4'(WEIGHT1 - 1);

   logic [3:0] r_cnt;
   logic       r_last;

   // NOTE: state registers use non-blocking assignments and an async reset in the sensitivity list.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_last  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (!vc0_empty && !vc1_empty) r_state <= r_last ? GRANT0 : GRANT1;
               else if (!vc0_empty)          r_state <= GRANT0;
               else if (!vc1_empty)          r_state <= GRANT1;
            end
            GRANT0: begin
               if (vc0_rd) begin
                  if (r_cnt == LP_LAST0) begin
                     r_cnt  <= '0;
                     r_last <= 1'b0;
                     if (!vc1_empty) r_state <= GRANT1;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end else if (vc0_empty) begin
                  r_cnt   <= '0;
                  r_last  <= 1'b0;
                  r_state <= vc1_empty ? IDLE : GRANT1;
               end
            end
            GRANT1: begin
               if (vc1_rd) begin
                  if (r_cnt == LP_LAST1) begin
                     r_cnt  <= '0;
                     r_last <= 1'b1;
                     if (!vc0_empty) r_state <= GRANT0;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end else if (vc1_empty) begin
                  r_cnt   <= '0;
                  r_last  <= 1'b1;
                  r_state <= vc0_empty ? IDLE : GRANT0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
`endif

   assign w_word      = r_src ? vc1_data : vc0_data;
   assign w_bad_class = r_src ? ~w_word[BW-1] : w_word[BW-1];

   // NOTE: a pop tags the source; the FIFO data arrives one cycle later and is routed then.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid    <= 1'b0;
         r_src      <= 1'b0;
         r_d0_wr    <= 1'b0;
         r_d1_wr    <= 1'b0;
         r_d_data   <= '0;
         r_misroute <= 1'b0;
      end else begin
         r_valid <= vc0_rd | vc1_rd;
         r_src   <= vc1_rd;
         r_d0_wr <= r_valid & ~w_word[BW-2];
         r_d1_wr <= r_valid &  w_word[BW-2];
         if (r_valid) begin
            r_d_data <= w_word;
            if (w_bad_class) r_misroute <= 1'b1;
         end
      end
   end

   assign d0_wr        = r_d0_wr;
   assign d1_wr        = r_d1_wr;
   assign d_data       = r_d_data;
   assign grant        = r_state;
   assign misroute_err = r_misroute;

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Directed bench for vc_wrr_scheduler: behavioural VC FIFOs feed the DUT, pops and writes are logged
// and compared against hand-derived orderings.
module tb_vc_wrr_scheduler;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       vc0_empty;
   logic       vc1_empty;
   logic [5:0] vc0_data;
   logic [5:0] vc1_data;
   logic       d0_pause;
   logic       d1_pause;
   logic       vc0_rd;
   logic       vc1_rd;
   logic       d0_wr;
   logic       d1_wr;
   logic [5:0] d_data;
   logic [1:0] grant;
   logic       misroute_err;

   vc_wrr_scheduler #(.BW(6), .WEIGHT0(3), .WEIGHT1(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .vc0_empty    (vc0_empty),
      .vc1_empty    (vc1_empty),
      .vc0_data     (vc0_data),
      .vc1_data     (vc1_data),
      .d0_pause     (d0_pause),
      .d1_pause     (d1_pause),
      .vc0_rd       (vc0_rd),
      .vc1_rd       (vc1_rd),
      .d0_wr        (d0_wr),
      .d1_wr        (d1_wr),
      .d_data       (d_data),
      .grant        (grant),
      .misroute_err (misroute_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks;
   int         n_fail;
   int         edge_n;
   logic       p_rd0;
   logic       p_rd1;
   logic [5:0] q0[$];
   logic [5:0] q1[$];
   int         pop_log[$];
   int         rd_edges[$];
   int         wr_edges[$];
   logic [5:0] d0_log[$];
   logic [5:0] d1_log[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample pops just before the edge, then model the FIFO read and log writes after it.
   task automatic step();
      #1;
      p_rd0 = vc0_rd;
      p_rd1 = vc1_rd;
      if (p_rd0 && p_rd1) check("one_rd_only", 32'(p_rd1), 32'd0);
      if (p_rd0) pop_log.push_back(0);
      if (p_rd1) pop_log.push_back(1);
      if (p_rd0 || p_rd1) rd_edges.push_back(edge_n + 1);
      @(posedge clk);
      edge_n++;
      #1;
      if (p_rd0 && q0.size() > 0) vc0_data = q0.pop_front();
      if (p_rd1 && q1.size() > 0) vc1_data = q1.pop_front();
      vc0_empty = (q0.size() == 0);
      vc1_empty = (q1.size() == 0);
      if (d0_wr) begin d0_log.push_back(d_data); wr_edges.push_back(edge_n); end
      if (d1_wr) begin d1_log.push_back(d_data); wr_edges.push_back(edge_n); end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_logs();
      pop_log.delete(); rd_edges.delete(); wr_edges.delete();
      d0_log.delete(); d1_log.delete();
   endtask

   task automatic push0(input logic [5:0] w);
      q0.push_back(w);
      vc0_empty = 1'b0;
   endtask

   task automatic push1(input logic [5:0] w);
      q1.push_back(w);
      vc1_empty = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      q0.delete(); q1.delete();
      vc0_empty = 1'b1; vc1_empty = 1'b1;
      vc0_data = '0; vc1_data = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_logs();
   endtask

   // Standard load: VC0 eight D0 words of class 0, VC1 four D1 words of class 1.
   task automatic load_std();
      for (int i = 0; i < 8; i++) push0({2'b00, 4'(i + 1)});
      for (int i = 0; i < 4; i++) push1({2'b11, 4'(i + 1)});
   endtask

   task automatic check_order(input string tag, input int exp_q[$]);
      check({tag, "_count"}, 32'(pop_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_pop%0d", tag, i), 32'(pop_log[i]), 32'(exp_q[i]));
   endtask

   task automatic check_std_delivery(input string tag);
      check({tag, "_d0_count"}, 32'(d0_log.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_d0_word%0d", tag, i), 32'(d0_log[i]), 32'({2'b00, 4'(i + 1)}));
      check({tag, "_d1_count"}, 32'(d1_log.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_d1_word%0d", tag, i), 32'(d1_log[i]), 32'({2'b11, 4'(i + 1)}));
   endtask

   int exp_q[$];

   initial begin
      n_checks = 0; n_fail = 0; edge_n = 0;
      p_rd0 = 1'b0; p_rd1 = 1'b0;
      reset = 1'b1; enable = 1'b1; d0_pause = 1'b0; d1_pause = 1'b0;
      vc0_empty = 1'b1; vc1_empty = 1'b1; vc0_data = '0; vc1_data = '0;
      #2;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_d0_wr", 32'(d0_wr), 32'd0);
      check("rst_d1_wr", 32'(d1_wr), 32'd0);
      check("rst_d_data", 32'(d_data), 32'd0);
      check("rst_misroute", 32'(misroute_err), 32'd0);
      do_reset();

`ifndef STRICT_PRIORITY_EN
      // Weighted round-robin 3/1 over a 8/4 load.
      load_std();
      steps(20);
      exp_q = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1};
      check_order("wrr", exp_q);
      check_std_delivery("wrr");
      check("wrr_wr_count", 32'(wr_edges.size()), 32'(rd_edges.size()));
      for (int i = 0; i < 12; i++)
         check($sformatf("wrr_latency%0d", i), 32'(wr_edges[i]), 32'(rd_edges[i] + 1));
      check("wrr_no_misroute", 32'(misroute_err), 32'd0);
      check("wrr_idle_at_end", 32'(grant), 32'd0);

      // d1_pause for five cycles after the second VC0 pop; cnt must survive the stall.
      do_reset();
      load_std();
      steps(3);
      check("pause_pre_pops", 32'(pop_log.size()), 32'd2);
      d1_pause = 1'b1;
      steps(5);
      check("pause_no_rd", 32'(pop_log.size()), 32'd2);
      check("pause_inflight_written", 32'(d0_log.size()), 32'd2);
      check("pause_grant_held", 32'(grant), 32'b01);
      d1_pause = 1'b0;
      step();
      check("pause_resume_count", 32'(pop_log.size()), 32'd3);
      check("pause_resume_vc", 32'(pop_log[2]), 32'd0);
      steps(20);
      check_order("pause", exp_q);
      check_std_delivery("pause");
`endif

      // Class mismatch from VC0: destination bit 0 routes to D0, error sticks.
      do_reset();
      push0(6'b10_0101);
      steps(4);
      check("misr_d0_count", 32'(d0_log.size()), 32'd1);
      check("misr_d0_word", 32'(d0_log[0]), 32'b10_0101);
      check("misr_d1_count", 32'(d1_log.size()), 32'd0);
      check("misr_flag", 32'(misroute_err), 32'd1);
      steps(3);
      check("misr_sticky", 32'(misroute_err), 32'd1);

      // Reset the cycle after a pop: word is dropped and outputs clear asynchronously.
      clear_logs();
      push0(6'b00_0111);
      steps(2);
      check("rstmid_popped", 32'(pop_log.size()), 32'd1);
      reset = 1'b1;
      #1;
      check("rstmid_grant", 32'(grant), 32'd0);
      check("rstmid_d0_wr", 32'(d0_wr), 32'd0);
      check("rstmid_d1_wr", 32'(d1_wr), 32'd0);
      check("rstmid_d_data", 32'(d_data), 32'd0);
      check("rstmid_misroute", 32'(misroute_err), 32'd0);
      clear_logs();
      push0(6'b00_0001);
      push1(6'b11_0001);
      step();
      check("rstmid_hold_no_wr", 32'(d0_log.size() + d1_log.size()), 32'd0);
      reset = 1'b0;
      step();
      check("rstmid_first_grant", 32'(grant), 32'b01);
      check("rstmid_dropped", 32'(d0_log.size() + d1_log.size()), 32'd0);

      // Enable low: grant may leave IDLE but nothing is popped.
      do_reset();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) push0({2'b00, 4'(i + 1)});
      for (int i = 0; i < 2; i++) push1({2'b11, 4'(i + 1)});
      steps(4);
      check("en_low_no_rd", 32'(pop_log.size()), 32'd0);
      check("en_low_grant", 32'(grant), 32'b01);
      enable = 1'b1;
      step();
      check("en_first_pop", 32'(pop_log.size()), 32'd1);
      check("en_first_vc", 32'(pop_log[0]), 32'd0);
      step();
      enable = 1'b0;
      steps(3);
      check("en_mid_no_rd", 32'(pop_log.size()), 32'd2);
      check("en_mid_inflight", 32'(d0_log.size()), 32'd2);
      check("en_mid_grant", 32'(grant), 32'b01);
      enable = 1'b1;
      steps(12);
      exp_q = '{0, 0, 0, 1, 1};
      check_order("en", exp_q);
      check("en_d1_count", 32'(d1_log.size()), 32'd2);

`ifdef STRICT_PRIORITY_EN
      // VC1 streaming; VC0 arrives and preempts on the next cycle.
      do_reset();
      for (int i = 0; i < 4; i++) push1({2'b11, 4'(i + 1)});
      steps(3);
      check("strict_vc1_pops", 32'(pop_log.size()), 32'd2);
      push0(6'b00_0001);
      push0(6'b00_0010);
      step();
      check("strict_switch_grant", 32'(grant), 32'b01);
      check("strict_no_vc1_pop", 32'(pop_log.size()), 32'd2);
      steps(15);
      exp_q = '{1, 1, 0, 0, 1, 1};
      check_order("strict", exp_q);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
